// File: rtl/spider_host_sequencer.sv
// =====================================================================
// Module   : spider_host_sequencer
// Brief    : Turns WRITE/START/READ/FENCE commands into NeuroSpider host-bus cycles.
// Revision : 1.0
// =====================================================================
`default_nettype none

module spider_host_sequencer #(
    parameter int READ_LATENCY   = 2,
    parameter int START_HOLDOFF  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        StartOperation,
    output logic        WE,
    output logic [15:0] Address,
    output logic [15:0] DataWrite,
    input  logic        ReadyNextOperation,
    input  logic [15:0] DataRead,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [1:0]  c_OP_WRITE = 2'b00;
    localparam logic [1:0]  c_OP_START = 2'b01;
    localparam logic [1:0]  c_OP_READ  = 2'b10;
    localparam logic [1:0]  c_OP_FENCE = 2'b11;

    localparam logic [15:0] c_RD_LAST   = 16'(READ_LATENCY - 1);
    localparam logic [15:0] c_HOLD_LAST = 16'(START_HOLDOFF - 1);
    localparam logic [15:0] c_TIMEOUT   = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_STRT = 3'd2,
        S_HOLD = 3'd3,
        S_WAIT = 3'd4,
        S_RD   = 3'd5,
        S_RSP  = 3'd6
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_we;
    logic        r_start;
    logic [15:0] r_addr;
    logic [15:0] r_dw;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_timeout;
    logic        r_ready_en;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_we_nxt;
    logic        w_start_nxt;
    logic [15:0] w_addr_nxt;
    logic [15:0] w_dw_nxt;
    logic        w_rsp_valid_nxt;
    logic [15:0] w_rsp_data_nxt;
    logic        w_timeout_nxt;
    logic        w_accept;
    logic [15:0] w_cnt_inc;

    // r_ready_en keeps cmd_ready low for the cycle immediately after a reset edge
    assign cmd_ready      = (r_state == S_IDLE) && !r_rsp_valid && r_ready_en;
    assign w_accept       = cmd_valid && cmd_ready;
    assign w_cnt_inc      = r_cnt + 16'd1;

    assign busy           = (r_state != S_IDLE);
    assign WE             = r_we;
    assign StartOperation = r_start;
    assign Address        = r_addr;
    assign DataWrite      = r_dw;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign timeout_err    = r_timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_we        <= 1'b0;
            r_start     <= 1'b0;
            r_addr      <= 16'd0;
            r_dw        <= 16'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'd0;
            r_timeout   <= 1'b0;
            r_ready_en  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_we        <= w_we_nxt;
            r_start     <= w_start_nxt;
            r_addr      <= w_addr_nxt;
            r_dw        <= w_dw_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_timeout   <= w_timeout_nxt;
            r_ready_en  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_we_nxt        = 1'b0;
        w_start_nxt     = 1'b0;
        w_addr_nxt      = r_addr;
        w_dw_nxt        = r_dw;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_timeout_nxt   = r_timeout;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = 16'd0;
                    case (cmd_op)
                        c_OP_WRITE: begin
                            w_state_nxt = S_WR;
                            w_we_nxt    = 1'b1;
                            w_addr_nxt  = cmd_addr;
                            w_dw_nxt    = cmd_data;
                        end
                        c_OP_START: begin
                            w_state_nxt = S_STRT;
                            w_start_nxt = 1'b1;
                        end
                        c_OP_READ: begin
                            w_state_nxt = S_RD;
                            w_addr_nxt  = cmd_addr;
                        end
                        c_OP_FENCE: begin
                            w_state_nxt = S_WAIT;
                        end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
                w_state_nxt = S_IDLE;
            end
            S_STRT: begin
                w_cnt_nxt   = 16'd0;
                w_state_nxt = (START_HOLDOFF == 0) ? S_WAIT : S_HOLD;
            end
            S_HOLD: begin
                // ReadyNextOperation is deliberately not looked at here
                if (r_cnt == c_HOLD_LAST) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (ReadyNextOperation) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_inc == c_TIMEOUT) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_RD: begin
                if (r_cnt == c_RD_LAST) begin
                    w_rsp_data_nxt  = DataRead;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RSP;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_spider_host_sequencer.sv
// =====================================================================
// Module   : tb_spider_host_sequencer
// Brief    : Directed-vector bench for spider_host_sequencer with a small bus stand-in.
// Revision : 1.0
// =====================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spider_host_sequencer;

    localparam int RL = 2;
    localparam int HO = 2;
    localparam int TO = 16;

    localparam logic [1:0] OP_WR = 2'b00;
    localparam logic [1:0] OP_ST = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_FN = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        StartOperation;
    logic        WE;
    logic [15:0] Address;
    logic [15:0] DataWrite;
    logic        ReadyNextOperation;
    logic [15:0] DataRead;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    spider_host_sequencer #(
        .READ_LATENCY   (RL),
        .START_HOLDOFF  (HO),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_addr           (cmd_addr),
        .cmd_data           (cmd_data),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_data           (rsp_data),
        .StartOperation     (StartOperation),
        .WE                 (WE),
        .Address            (Address),
        .DataWrite          (DataWrite),
        .ReadyNextOperation (ReadyNextOperation),
        .DataRead           (DataRead),
        .busy               (busy),
        .timeout_err        (timeout_err)
    );

    // Bus stand-in: unwritten words read as 0x5A<addr>; data reflects the address one cycle late,
    // so with RL=2 only the last held cycle returns the requested word.
    logic [15:0]  mem [0:255];
    logic [255:0] written;
    logic         mem_clr;
    logic [15:0]  addr_q;

    always @(posedge clk) begin
        addr_q <= Address;
        if (mem_clr) begin
            written <= '0;
        end else if (WE) begin
            mem[Address[7:0]]     <= DataWrite;
            written[Address[7:0]] <= 1'b1;
        end
    end

    assign DataRead = written[addr_q[7:0]] ? mem[addr_q[7:0]] : {8'h5A, addr_q[7:0]};

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] data;
        logic        rno;
        int          busy_cyc;
        logic [15:0] exp_addr;
        logic [15:0] exp_rsp;
        logic        exp_to;
    } vec_t;

    vec_t vecs [10];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data,
                         input logic rno, input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_op             = op;
        cmd_addr           = addr;
        cmd_data           = data;
        ReadyNextOperation = rno;
        cmd_valid          = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 16'hFFFF;
        cmd_data  = 16'hFFFF;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          bcnt, wcnt, scnt;
        logic        rdy_bad, first_we;
        logic [15:0] addr_seen, dw_seen, rsp_seen;
        string       tag;
        tag = $sformatf("v%0d", idx);
        issue(v.op, v.addr, v.data, v.rno, tag);
        @(negedge clk);
        addr_seen = Address;
        dw_seen   = DataWrite;
        first_we  = WE;
        bcnt = 0; wcnt = 0; scnt = 0; rdy_bad = 1'b0; rsp_seen = 16'h0000;
        while (busy && bcnt < 100) begin
            bcnt++;
            if (WE) wcnt++;
            if (StartOperation) scnt++;
            if (cmd_ready) rdy_bad = 1'b1;
            if (rsp_valid) rsp_seen = rsp_data;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'(v.busy_cyc));
        check({tag, "_we_first"}, {31'd0, first_we}, {31'd0, (v.op == OP_WR)});
        check({tag, "_we_count"}, 32'(wcnt), (v.op == OP_WR) ? 32'd1 : 32'd0);
        check({tag, "_start_count"}, 32'(scnt), (v.op == OP_ST) ? 32'd1 : 32'd0);
        check({tag, "_addr"}, {16'd0, addr_seen}, {16'd0, v.exp_addr});
        check({tag, "_ready_low_while_busy"}, {31'd0, rdy_bad}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout_err}, {31'd0, v.exp_to});
        if (v.op == OP_WR) check({tag, "_datawrite"}, {16'd0, dw_seen}, {16'd0, v.data});
        if (v.op == OP_RD) check({tag, "_rsp_data"}, {16'd0, rsp_seen}, {16'd0, v.exp_rsp});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nacc, g;
        logic        pend;
        logic [3:0]  pat;
        vec_t        wv;

        //        op     addr      data      rno   busy    exp_addr  exp_rsp   to
        vecs[0] = '{OP_WR, 16'h0012, 16'hBEEF, 1'b0, 1,      16'h0012, 16'h0000, 1'b0};
        vecs[1] = '{OP_WR, 16'h8003, 16'h0004, 1'b0, 1,      16'h8003, 16'h0000, 1'b0};
        vecs[2] = '{OP_RD, 16'h0012, 16'h0000, 1'b0, RL+1,   16'h0012, 16'hBEEF, 1'b0};
        vecs[3] = '{OP_RD, 16'h0034, 16'h0000, 1'b0, RL+1,   16'h0034, 16'h5A34, 1'b0};
        vecs[4] = '{OP_ST, 16'h0000, 16'h0000, 1'b1, HO+2,   16'h0034, 16'h0000, 1'b0};
        vecs[5] = '{OP_FN, 16'h0000, 16'h0000, 1'b1, 1,      16'h0034, 16'h0000, 1'b0};
        vecs[6] = '{OP_ST, 16'h0000, 16'h0000, 1'b0, HO+1+TO, 16'h0034, 16'h0000, 1'b1};
        vecs[7] = '{OP_WR, 16'h0055, 16'hA5A5, 1'b0, 1,      16'h0055, 16'h0000, 1'b1};
        vecs[8] = '{OP_RD, 16'h0055, 16'h0000, 1'b0, RL+1,   16'h0055, 16'hA5A5, 1'b1};
        vecs[9] = '{OP_FN, 16'h0000, 16'h0000, 1'b0, TO,     16'h0055, 16'h0000, 1'b1};

        rst_n = 1'b0; mem_clr = 1'b1; cmd_valid = 1'b0; cmd_op = OP_WR;
        cmd_addr = 16'h0000; cmd_data = 16'h0000; rsp_ready = 1'b1; ReadyNextOperation = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_outputs", {26'd0, WE, StartOperation, rsp_valid, busy, timeout_err, (Address != 16'd0)}, 32'd0);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // back-to-back writes with cmd_valid held high
        cmd_op = OP_WR; cmd_addr = 16'h0040; cmd_data = 16'h1111; cmd_valid = 1'b1;
        pend = cmd_ready; nacc = 0; pat = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pat = {pat[2:0], WE};
            if (k == 2) begin
                check("b2b_addr2", {16'd0, Address}, 32'h0041);
                check("b2b_dw2", {16'd0, DataWrite}, 32'h2222);
            end
            if (pend) begin
                nacc++;
                if (nacc == 1) begin
                    cmd_addr = 16'h0041;
                    cmd_data = 16'h2222;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            pend = cmd_valid && cmd_ready;
        end
        check("b2b_we_pattern", {28'd0, pat}, 32'hA);
        check("b2b_accepts", 32'(nacc), 32'd2);
        check("b2b_addr_held", {16'd0, Address}, 32'h0041);

        // response back-pressure
        rsp_ready = 1'b0;
        issue(OP_RD, 16'h0040, 16'h0000, 1'b0, "bp");
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!rsp_valid && g < 20);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp%0d_rsp_data", k), {16'd0, rsp_data}, 32'h1111);
            check($sformatf("bp%0d_cmd_ready", k), {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_consumed", {30'd0, rsp_valid, busy}, 32'd0);

        // reset while in HOLD (timeout_err is still set from earlier)
        issue(OP_ST, 16'h0000, 16'h0000, 1'b1, "hrst");
        @(negedge clk);
        check("hrst_start_pulse", {31'd0, StartOperation}, 32'd1);
        @(negedge clk);
        check("hrst_in_hold", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("hrst_outputs", {27'd0, WE, StartOperation, rsp_valid, busy, timeout_err}, 32'd0);
        check("hrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("hrst_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        wv = '{OP_WR, 16'h0077, 16'h3C3C, 1'b0, 1, 16'h0077, 16'h0000, 1'b0};
        run_vec(10, wv);

        // reset while a response is pending
        rsp_ready = 1'b0;
        issue(OP_RD, 16'h0055, 16'h0000, 1'b0, "rrst");
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!rsp_valid && g < 20);
        check("rrst_rsp_data", {16'd0, rsp_data}, 32'hA5A5);
        rst_n = 1'b0;
        @(negedge clk);
        check("rrst_outputs", {29'd0, rsp_valid, busy, WE}, 32'd0);
        check("rrst_rsp_cleared", {16'd0, rsp_data}, 32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        wv = '{OP_WR, 16'h0078, 16'h0F0F, 1'b0, 1, 16'h0078, 16'h0000, 1'b0};
        run_vec(11, wv);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
